// File: rtl/select_debouncer.sv
// Synchronises, debounces and optionally auto-repeats the select pushbutton into one-clock pulses.
// Latency btn_raw rise to select_pulse: SYNC_STAGES + DEBOUNCE_CYCLES clks (+/-1); no backpressure.
module select_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic select_pulse,
    output logic btn_state
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST   = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       rcnt_q, rcnt_d;
    logic                rfirst_q, rfirst_d;
    logic                pulse_q, pulse_d;
    logic                state_out_q, state_out_d;
    logic                btn_sync;

    assign btn_sync     = sync_q[SYNC_STAGES-1];
    assign select_pulse = pulse_q;
    assign btn_state    = state_out_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            rfirst_q    <= 1'b1;
            pulse_q     <= 1'b0;
            state_out_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            rfirst_q    <= rfirst_d;
            pulse_q     <= pulse_d;
            state_out_q <= state_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        rfirst_d    = rfirst_q;
        pulse_d     = 1'b0;
        state_out_d = state_out_q;
        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = ARM_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM_PRESS: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    pulse_d     = 1'b1;
                    state_out_d = 1'b1;
                    rcnt_d      = '0;
                    rfirst_d    = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = CNT_ONE;
                end else if (REPEAT_EN != 0) begin
                    // First repeat waits the long delay, later ones the shorter period.
                    if (rcnt_q == (rfirst_q ? DELAY_LAST : PER_LAST)) begin
                        pulse_d  = 1'b1;
                        rcnt_d   = '0;
                        rfirst_d = 1'b0;
                    end else begin
                        rcnt_d = sat_inc(rcnt_q);
                    end
                end
            end
            ARM_RELEASE: begin
                if (btn_sync) begin
                    state_d  = PRESSED;
                    rcnt_d   = '0;
                    rfirst_d = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    state_out_d = 1'b0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_select_debouncer.sv
// Drives a plain and an auto-repeat debouncer with directed and random button activity,
// comparing both against a run-length model of the debounce rules every cycle.
module tb_select_debouncer;

    localparam int SYNC   = 2;
    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 5;

    logic clk;
    logic reset;
    logic btn_raw;
    logic pulse0, state0, pulse1, state1;

    int total = 0;
    int bad   = 0;

    select_debouncer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) u_dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .select_pulse(pulse0), .btn_state(state0)
    );

    select_debouncer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) u_rpt (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .select_pulse(pulse1), .btn_state(state1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the sample seen by the debounce logic is btn_raw delayed by SYNC
    // edges; a level is accepted after DEB consecutive samples differing from the current one.
    bit hist[$];
    int acc[2], run[2], held[2], ep[2], es[2];
    int mcnt, dcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
            for (int r = 0; r < 2; r++) begin
                acc[r] = 0; run[r] = 0; held[r] = 0; ep[r] = 0; es[r] = 0;
            end
            mcnt = 0;
        end else begin
            int samp;
            samp = int'(hist.pop_front());
            hist.push_back(btn_raw);
            if (ep[0] != 0) mcnt = (mcnt + 1) % 4;
            for (int r = 0; r < 2; r++) begin
                ep[r] = 0;
                if (samp != acc[r]) begin
                    run[r]++;
                    if (run[r] == DEB) begin
                        acc[r] = samp;
                        es[r]  = samp;
                        run[r] = 0;
                        if (samp == 1) begin
                            ep[r]   = 1;
                            held[r] = 0;
                        end
                    end
                end else begin
                    if (acc[r] == 1) begin
                        if (run[r] != 0) begin
                            held[r] = 0;
                        end else if (r == 1) begin
                            held[r]++;
                            if (held[r] == DELAY ||
                                (held[r] > DELAY && (held[r] - DELAY) % PERIOD == 0))
                                ep[r] = 1;
                        end
                    end
                    run[r] = 0;
                end
            end
        end
    end

    // Downstream 2-bit select counter clocked from the plain debouncer's pulse.
    always @(posedge clk or posedge reset) begin
        if (reset) dcnt <= 0;
        else if (pulse0) dcnt <= (dcnt + 1) % 4;
    end

    int np0 = 0, np1 = 0;
    always @(negedge clk) begin
        chk("pulse", int'(pulse0), ep[0]);
        chk("state", int'(state0), es[0]);
        chk("rpt_pulse", int'(pulse1), ep[1]);
        chk("rpt_state", int'(state1), es[1]);
        chk("count", dcnt, mcnt);
        if (pulse0) np0++;
        if (pulse1) np1++;
    end

    task automatic hold(input bit v, input int n);
        btn_raw = v;
        repeat (n) @(negedge clk);
    endtask

    // Asserts reset between edges, checks the outputs clear at once, then releases it.
    task automatic async_reset(input string name);
        #2 reset = 1'b1;
        #1;
        chk({name, "_pulse_async"}, int'(pulse0 | pulse1), 0);
        chk({name, "_state_async"}, int'(state0 | state1), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lat, s0, s1;
        reset   = 1'b1;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pulse", int'(pulse0), 0);
        chk("reset_state", int'(state0), 0);
        reset = 1'b0;
        hold(0, 5);

        // Clean press: pulse 6 clks after the raw edge, one clock wide.
        s0 = np0;
        btn_raw = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (pulse0) break;
        end
        chk("press_latency", lat, 6);
        @(negedge clk);
        chk("pulse_width", int'(pulse0), 0);
        hold(1, 12);
        chk("press_count", np0 - s0, 1);
        chk("press_state", int'(state0), 1);
        hold(0, 10);
        chk("release_state", int'(state0), 0);

        // Press bounce.
        s0 = np0;
        hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 2); hold(1, 12);
        chk("bounce_press_count", np0 - s0, 1);

        // Release bounce.
        s0 = np0;
        hold(0, 2); hold(1, 4); hold(0, 12);
        chk("bounce_release_count", np0 - s0, 0);
        chk("bounce_release_state", int'(state0), 0);

        // Auto-repeat while held 30 clks.
        s0 = np0; s1 = np1;
        hold(1, 30); hold(0, 20);
        chk("repeat_count", np1 - s1, 5);
        chk("norepeat_count", np0 - s0, 1);

        // Reset while pressed and still held afterwards: new press after debounce.
        hold(1, 10);
        async_reset("held");
        s0 = np0;
        hold(1, 10);
        chk("held_after_reset", np0 - s0, 1);
        hold(0, 10);

        // Four presses wrap the 2-bit counter; a 5th is aborted by reset.
        async_reset("pre_count");
        hold(0, 4);
        for (int k = 1; k <= 4; k++) begin
            hold(1, 8); hold(0, 8);
            chk("wrap_count", dcnt, k % 4);
        end
        s0 = np0;
        hold(1, 3);
        async_reset("mid_press");
        btn_raw = 1'b0;
        hold(0, 10);
        chk("abort_count", dcnt, 0);
        chk("abort_pulses", np0 - s0, 0);

        // Random activity with occasional resets.
        for (int it = 0; it < 250; it++) begin
            int len;
            if ($urandom_range(0, 49) == 0) async_reset("rand");
            if ($urandom_range(0, 4) == 0) len = $urandom_range(10, 40);
            else len = $urandom_range(1, 6);
            hold(bit'($urandom_range(0, 1)), len);
        end
        hold(0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
